// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - CPU, host and data_mem signal bundle for dmem_arbiter
interface dmem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_adr;
  logic [DW-1:0] cpu_din;
  logic          cpu_stall;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;

  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_adr;
  logic [DW-1:0] host_din;
  logic          host_ready;
  logic          host_rvalid;
  logic [DW-1:0] host_rdata;

  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_din;
  logic          mem_we;
  logic [DW-1:0] mem_dout;

  modport slave (
    input  cpu_req, cpu_we, cpu_adr, cpu_din,
    output cpu_stall, cpu_rvalid, cpu_rdata,
    input  host_req, host_we, host_adr, host_din,
    output host_ready, host_rvalid, host_rdata,
    output mem_adr, mem_din, mem_we,
    input  mem_dout
  );

  modport master (
    output cpu_req, cpu_we, cpu_adr, cpu_din,
    input  cpu_stall, cpu_rvalid, cpu_rdata,
    output host_req, host_we, host_adr, host_din,
    input  host_ready, host_rvalid, host_rdata,
    input  mem_adr, mem_din, mem_we,
    output mem_dout
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - single-port data_mem arbiter, CPU priority with guaranteed host bursts
module dmem_arbiter #(
  parameter int AW          = 8,
  parameter int DW          = 8,
  parameter int MAX_CPU_RUN = 4,
  parameter int HOST_BURST  = 2
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);
  localparam int RW = $clog2(MAX_CPU_RUN + 1);
  localparam int BW = $clog2(HOST_BURST + 1);

  typedef enum logic {CPU_PRI = 1'b0, HOST_PRI = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] run_cnt_q, run_cnt_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  logic          cpu_rvalid_q, cpu_rvalid_d;
  logic          host_rvalid_q, host_rvalid_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] host_rdata_q, host_rdata_d;
  logic          gnt_cpu, gnt_host;

  always_comb begin
    state_d    = state_q;
    run_cnt_d  = run_cnt_q;
    beat_cnt_d = beat_cnt_q;
    gnt_cpu    = 1'b0;
    gnt_host   = 1'b0;
    unique case (state_q)
      CPU_PRI: begin
        if (bus.cpu_req && bus.host_req) begin
          if (run_cnt_q == RW'(MAX_CPU_RUN)) begin
            gnt_host   = 1'b1;
            run_cnt_d  = '0;
            beat_cnt_d = BW'(1);
            state_d    = (HOST_BURST > 1) ? HOST_PRI : CPU_PRI;
          end else begin
            gnt_cpu   = 1'b1;
            run_cnt_d = run_cnt_q + 1'b1;
          end
        end else begin
          // Any cycle without contention breaks the CPU's run.
          gnt_cpu   = bus.cpu_req;
          gnt_host  = bus.host_req;
          run_cnt_d = '0;
        end
      end
      HOST_PRI: begin
        if (bus.host_req) begin
          gnt_host = 1'b1;
          if (beat_cnt_q < BW'(HOST_BURST)) beat_cnt_d = beat_cnt_q + 1'b1;
          if (int'(beat_cnt_q) + 1 >= HOST_BURST) state_d = CPU_PRI;
        end else begin
          gnt_cpu    = bus.cpu_req;
          beat_cnt_d = '0;
          run_cnt_d  = '0;
          state_d    = CPU_PRI;
        end
      end
      default: state_d = CPU_PRI;
    endcase
  end

  always_comb begin
    bus.mem_adr = '0;
    bus.mem_din = '0;
    bus.mem_we  = 1'b0;
    if (gnt_cpu) begin
      bus.mem_adr = bus.cpu_adr;
      bus.mem_din = bus.cpu_din;
      bus.mem_we  = bus.cpu_we & reset;
    end else if (gnt_host) begin
      bus.mem_adr = bus.host_adr;
      bus.mem_din = bus.host_din;
      bus.mem_we  = bus.host_we & reset;
    end
  end

  always_comb begin
    cpu_rvalid_d  = gnt_cpu & ~bus.cpu_we;
    host_rvalid_d = gnt_host & ~bus.host_we;
    cpu_rdata_d   = cpu_rvalid_d ? bus.mem_dout : cpu_rdata_q;
    host_rdata_d  = host_rvalid_d ? bus.mem_dout : host_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= CPU_PRI;
      run_cnt_q     <= '0;
      beat_cnt_q    <= '0;
      cpu_rvalid_q  <= 1'b0;
      host_rvalid_q <= 1'b0;
      cpu_rdata_q   <= '0;
      host_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      run_cnt_q     <= run_cnt_d;
      beat_cnt_q    <= beat_cnt_d;
      cpu_rvalid_q  <= cpu_rvalid_d;
      host_rvalid_q <= host_rvalid_d;
      cpu_rdata_q   <= cpu_rdata_d;
      host_rdata_q  <= host_rdata_d;
    end
  end

  assign bus.cpu_stall   = bus.cpu_req & ~gnt_cpu;
  assign bus.host_ready  = gnt_host;
  assign bus.cpu_rvalid  = cpu_rvalid_q;
  assign bus.cpu_rdata   = cpu_rdata_q;
  assign bus.host_rvalid = host_rvalid_q;
  assign bus.host_rdata  = host_rdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized and directed bench for dmem_arbiter against a burst-credit model
module tb_dmem_arbiter;
  localparam int MAX_RUN = 4;
  localparam int BURST   = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(8), .DW(8)) bus ();

  dmem_arbiter #(.AW(8), .DW(8), .MAX_CPU_RUN(MAX_RUN), .HOST_BURST(BURST)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Environment copy of data_mem: combinational read, clocked write.
  logic [7:0] mem_arr [256];
  assign bus.mem_dout = mem_arr[bus.mem_adr];
  always @(posedge clk) if (bus.mem_we) mem_arr[bus.mem_adr] <= bus.mem_din;

  // Reference model: memory contents, contended-run length, host beats still owed.
  logic [7:0] ref_mem [256];
  int m_run, m_left, last_win;
  logic e_crv, e_hrv;
  logic [7:0] e_crd, e_hrd;
  int n_tests = 0, n_fail = 0;
  int pat [12];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic rst_n, input logic creq, input logic cwe, input logic [7:0] cadr,
                      input logic [7:0] cdin, input logic hreq, input logic hwe,
                      input logic [7:0] hadr, input logic [7:0] hdin);
    int win;
    logic [7:0] ea, ed;
    logic ew;
    @(negedge clk);
    reset = rst_n;
    bus.cpu_req = creq; bus.cpu_we = cwe; bus.cpu_adr = cadr; bus.cpu_din = cdin;
    bus.host_req = hreq; bus.host_we = hwe; bus.host_adr = hadr; bus.host_din = hdin;
    #2;
    win = 0;
    if (m_left > 0) begin
      if (hreq) begin win = 2; m_left--; end
      else begin m_left = 0; win = creq ? 1 : 0; end
      m_run = 0;
    end else if (creq && hreq) begin
      if (m_run == MAX_RUN) begin win = 2; m_run = 0; m_left = BURST - 1; end
      else begin win = 1; m_run++; end
    end else begin
      win = creq ? 1 : (hreq ? 2 : 0);
      m_run = 0;
    end
    ea = (win == 1) ? cadr : (win == 2) ? hadr : 8'h00;
    ed = (win == 1) ? cdin : (win == 2) ? hdin : 8'h00;
    ew = rst_n && ((win == 1 && cwe) || (win == 2 && hwe));
    check("cpu_stall", bus.cpu_stall, creq && win != 1);
    check("host_ready", bus.host_ready, win == 2);
    check("mem_we", bus.mem_we, ew);
    check("mem_adr", bus.mem_adr, ea);
    check("mem_din", bus.mem_din, ed);
    check("cpu_rvalid", bus.cpu_rvalid, e_crv);
    check("cpu_rdata", bus.cpu_rdata, e_crd);
    check("host_rvalid", bus.host_rvalid, e_hrv);
    check("host_rdata", bus.host_rdata, e_hrd);
    if (!rst_n) begin
      m_run = 0; m_left = 0;
      e_crv = 1'b0; e_hrv = 1'b0; e_crd = 8'h00; e_hrd = 8'h00;
    end else begin
      e_crv = (win == 1) && !cwe;
      e_hrv = (win == 2) && !hwe;
      if (e_crv) e_crd = ref_mem[cadr];
      if (e_hrv) e_hrd = ref_mem[hadr];
      if (ew) ref_mem[ea] = ed;
    end
    last_win = win;
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  initial begin
    logic hreq, hwe;
    logic [7:0] hadr, hdin;
    for (int i = 0; i < 256; i++) begin mem_arr[i] = 8'h00; ref_mem[i] = 8'h00; end
    m_run = 0; m_left = 0; last_win = 0;
    e_crv = 1'b0; e_hrv = 1'b0; e_crd = 8'h00; e_hrd = 8'h00;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_adr = 8'h00; bus.cpu_din = 8'h00;
    bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_adr = 8'h00; bus.host_din = 8'h00;
    repeat (2) @(posedge clk);

    // Store during reset is suppressed, then lands once released.
    step(1'b0, 1'b1, 1'b1, 8'h10, 8'h3C, 1'b0, 1'b0, 8'h00, 8'h00);
    check("rst_mem_we", bus.mem_we, 1'b0);
    step(1'b1, 1'b1, 1'b1, 8'h10, 8'h3C, 1'b0, 1'b0, 8'h00, 8'h00);
    check("t1_mem_adr", bus.mem_adr, 8'h10);
    check("t1_stall", bus.cpu_stall, 1'b0);

    // Host write then read-back.
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h20, 8'hA5);
    check("t2_ready", bus.host_ready, 1'b1);
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00);
    idle();
    check("t2_rvalid", bus.host_rvalid, 1'b1);
    check("t2_rdata", bus.host_rdata, 8'hA5);

    // Sustained contention: C,C,C,C,H,H repeating.
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b1, 1'b0, 8'(i), 8'h00, 1'b1, 1'b0, 8'h20, 8'h00);
      pat[i] = bus.host_ready ? 2 : 1;
    end
    for (int i = 0; i < 12; i++) check("t3_grant", pat[i], ((i % 6) >= 4) ? 2 : 1);

    // Dropping host_req restarts the CPU run.
    idle();
    repeat (3) step(1'b1, 1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00);
    step(1'b1, 1'b1, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0, 8'h20, 8'h00);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00);
      check("t4_grant", bus.host_ready, i == 4);
    end

    // Host releases after one burst beat: CPU wins at once, back to CPU priority.
    step(1'b1, 1'b1, 1'b1, 8'h30, 8'h77, 1'b0, 1'b0, 8'h00, 8'h00);
    check("t5_cpu_now", bus.cpu_stall, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'h30, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00);
    check("t5_cpu_pri", bus.host_ready, 1'b0);

    // Load granted in the reset cycle produces no read data.
    idle();
    step(1'b0, 1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    idle();
    check("t6_rvalid", bus.cpu_rvalid, 1'b0);
    check("t6_rdata", bus.cpu_rdata, 8'h00);

    hreq = 1'b0; hwe = 1'b0; hadr = 8'h00; hdin = 8'h00;
    for (int n = 0; n < 600; n++) begin
      if (!(hreq && last_win != 2)) begin
        hreq = ($urandom_range(0, 3) != 0);
        hwe  = $urandom_range(0, 1) == 1;
        hadr = 8'($urandom_range(0, 15));
        hdin = 8'($urandom);
      end
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
           8'($urandom_range(0, 15)), 8'($urandom), hreq, hwe, hadr, hdin);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
